// File: rtl/reset_button_conditioner.sv
// Board front end: SoC reset sequencing from board reset + PLL lock,
// and button synchronise/debounce with gated press/release pulses.
module reset_button_conditioner #(
    parameter int unsigned CLK_FREQ        = 20_250_000,
    parameter int unsigned RST_HOLD_CYCLES = 1024,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock,
    input  logic btn,
    output logic soc_rst,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned HCW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic           BTN_IDLE  = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN
    } state_e;

    state_e         state_q, state_d;
    logic [HCW-1:0] cnt_q, cnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           lock_m_q, lock_s_q;
    logic           btn_m_q, btn_raw_q;
    logic           btn_s;
    logic           soc_rst_q, soc_rst_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           accept;

    // Pin-level synchronisers; the button pair resets to the released pin value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m_q  <= 1'b0;
            lock_s_q  <= 1'b0;
            btn_m_q   <= BTN_IDLE;
            btn_raw_q <= BTN_IDLE;
        end else begin
            lock_m_q  <= lock;
            lock_s_q  <= lock_m_q;
            btn_m_q   <= btn;
            btn_raw_q <= btn_m_q;
        end
    end

    assign btn_s = btn_raw_q ^ BTN_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            soc_rst_q <= 1'b1;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            soc_rst_q <= soc_rst_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = '0;
        level_d   = level_q;
        accept    = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HCW'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        soc_rst_d = (state_d != RUN);

        if (btn_s != level_q) begin
            if (dcnt_q == DEB_LAST) begin
                accept  = 1'b1;
                level_d = btn_s;
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end

        // Gate on the reset value that will be visible during the pulse cycle.
        press_d   = accept &  btn_s & ~soc_rst_d;
        release_d = accept & ~btn_s & ~soc_rst_d;
    end

    assign soc_rst     = soc_rst_q;
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
